alu_flags_seq: RTL and testbench



---
 rtl/alu_flags_seq.sv | 148 ++++++++++++++
 tb/tb_alu_flags_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_flags_seq.sv
// Sequential ALU with a registered NZCV flags register and multi-cycle shifts.
// Latency: 1 cycle for non-shift ops and k=0 shifts, k+1 cycles for shifts by k>0.
// Backpressure: in_ready is low outside IDLE; result/flags/out_valid hold until out_ready.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   A, B, ALUControl      operands and opcode (B[$clog2(WIDTH)-1:0] is the shift amount)
//   set_flags             update flags when this op completes
//   in_valid / in_ready   operation handshake
//   result, out_valid     registered result, held until out_ready
//   out_ready             downstream accepts result
//   flags                 registered {N,Z,C,V}
module alu_flags_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  input  logic             set_flags,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       flags
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] CNT_ONE = {{(KW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] work_q;   // operand being shifted
  logic [KW-1:0]    cnt_q;    // remaining shift steps
  logic             shl_q;    // 1 = shift left, 0 = shift right
  logic             sf_q;     // latched set_flags

  logic [KW-1:0]    k_in;
  logic             is_shift;
  logic             go_shift;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  logic [WIDTH-1:0] shift_nx;
  logic             shift_out;

  assign k_in     = B[KW-1:0];
  assign is_shift = (ALUControl[2:1] == 2'b11);
  assign go_shift = is_shift && (k_in != '0);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle ops, evaluated on the accepting edge. C and V default to
  // their current value so logic ops and k=0 shifts preserve them.
  always_comb begin
    sum_w   = '0;
    alu_res = A;
    alu_c   = flags[1];
    alu_v   = flags[0];
    case (ALUControl)
      3'b000: begin
        sum_w   = {1'b0, A} + {1'b0, B};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      3'b001: begin
        sum_w   = {1'b0, A} - {1'b0, B};
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = ~sum_w[WIDTH];  // top bit set means a borrow occurred
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
      end
      3'b010:  alu_res = A ^ B;
      3'b011:  alu_res = ~A;
      3'b100:  alu_res = A & B;
      3'b101:  alu_res = A | B;
      default: alu_res = A;       // shift by zero passes A through
    endcase
  end

  // One shift step on the working register and the bit leaving it.
  always_comb begin
    shift_nx  = shl_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
    shift_out = shl_q ? work_q[WIDTH-1] : work_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = go_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == CNT_ONE) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result and flags are only written on the edge that enters DONE, so they
  // cannot change while out_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      shl_q  <= 1'b0;
      sf_q   <= 1'b0;
      result <= '0;
      flags  <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work_q <= A;
            cnt_q  <= k_in;
            shl_q  <= ~ALUControl[0];
            sf_q   <= set_flags;
            if (!go_shift) begin
              result <= alu_res;
              if (set_flags)
                flags <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
          end
        end
        SHIFT: begin
          work_q <= shift_nx;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            result <= shift_nx;
            if (sf_q)
              flags <= {shift_nx[WIDTH-1], (shift_nx == '0), shift_out, flags[0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flags_seq.sv
module tb_alu_flags_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] A, B;
  logic [2:0] ALUControl;
  logic       set_flags, in_valid, in_ready, out_valid, out_ready;
  logic [3:0] result, flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] mflags;  // reference NZCV

  alu_flags_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .ALUControl(ALUControl),
    .set_flags(set_flags), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_valid(out_valid), .out_ready(out_ready), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a, b;
    logic       sf;
    int         stall;
    logic [3:0] exp_r, exp_f;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode definitions.
  task automatic model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic sf, output logic [3:0] r, output int lat);
    int ai = a, bi = b, k = b % 4, s = 0;
    int sa = (a >= 8) ? a - 16 : a;
    int sb = (b >= 8) ? b - 16 : b;
    logic c = mflags[1], v = mflags[0];
    case (op)
      3'd0: begin s = ai + bi; c = (s >= 16); v = (sa + sb > 7) || (sa + sb < -8); end
      3'd1: begin s = ai - bi + 16; c = (ai >= bi); v = (sa - sb > 7) || (sa - sb < -8); end
      3'd2: s = ai ^ bi;
      3'd3: s = 15 - ai;
      3'd4: s = ai & bi;
      3'd5: s = ai | bi;
      3'd6: begin s = ai << k; if (k > 0) c = ((ai >> (4 - k)) & 1) == 1; end
      default: begin s = ai >> k; if (k > 0) c = ((ai >> (k - 1)) & 1) == 1; end
    endcase
    r   = 4'(s % 16);
    lat = (op >= 3'd6 && k > 0) ? k + 1 : 1;
    if (sf) mflags = {r[3], (r == 4'd0), c, v};
  endtask

  // Issue one op, measure latency, optionally stall, then hand the result off.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic sf, input int stall,
                       input logic [3:0] er, input logic [3:0] ef, input int elat);
    int n;
    @(negedge clk);
    A = a; B = b; ALUControl = op; set_flags = sf; in_valid = 1'b1;
    chk({tag, " in_ready_idle"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; A = 4'($urandom); B = 4'($urandom);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, elat);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, flags, ef);
    chk({tag, " in_ready_busy"}, in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = (i % 2 == 0);
      A = 4'($urandom); ALUControl = 3'($urandom); set_flags = 1'b1;
      @(posedge clk); #1;
      chk({tag, " stall_valid"}, out_valid, 1);
      chk({tag, " stall_result"}, result, er);
      chk({tag, " stall_flags"}, flags, ef);
      chk({tag, " stall_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " drained"}, out_valid, 0);
    chk({tag, " ready_again"}, in_ready, 1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [3:0] r;
    int lat;
    vec_t v;

    rst_n = 1'b0; A = '0; B = '0; ALUControl = '0; set_flags = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; mflags = 4'b0000;
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset result", result, 0);
    chk("reset flags", flags, 0);
    #12 rst_n = 1'b1;

    //        op    a      b      sf  stall  result flags(NZCV) lat
    vecs.push_back('{3'd0, 4'd3,  4'd14, 1'b1, 0, 4'd1,  4'b0010, 1});
    vecs.push_back('{3'd1, 4'd2,  4'd6,  1'b1, 0, 4'd12, 4'b1000, 1});
    vecs.push_back('{3'd0, 4'd7,  4'd1,  1'b1, 0, 4'd8,  4'b1001, 1});
    vecs.push_back('{3'd0, 4'd15, 4'd15, 1'b1, 0, 4'd14, 4'b1010, 1});
    vecs.push_back('{3'd0, 4'd8,  4'd8,  1'b1, 0, 4'd0,  4'b0111, 1});
    vecs.push_back('{3'd2, 4'd7,  4'd4,  1'b1, 0, 4'd3,  4'b0011, 1});
    vecs.push_back('{3'd3, 4'd3,  4'd9,  1'b1, 0, 4'd12, 4'b1011, 1});
    vecs.push_back('{3'd6, 4'd7,  4'd3,  1'b1, 0, 4'd8,  4'b1011, 4});
    vecs.push_back('{3'd7, 4'd1,  4'd0,  1'b1, 0, 4'd1,  4'b0011, 1});
    vecs.push_back('{3'd0, 4'd2,  4'd6,  1'b0, 5, 4'd8,  4'b0011, 1});
    vecs.push_back('{3'd7, 4'd9,  4'd2,  1'b1, 0, 4'd2,  4'b0001, 3});
    vecs.push_back('{3'd1, 4'd5,  4'd5,  1'b1, 1, 4'd0,  4'b0110, 1});
    vecs.push_back('{3'd4, 4'd12, 4'd10, 1'b1, 0, 4'd8,  4'b1010, 1});
    vecs.push_back('{3'd5, 4'd0,  4'd0,  1'b1, 0, 4'd0,  4'b0110, 1});

    foreach (vecs[i]) begin
      v = vecs[i];
      model(v.op, v.a, v.b, v.sf, r, lat);  // keeps reference flags in step
      do_op($sformatf("vec%0d", i), v.op, v.a, v.b, v.sf, v.stall, v.exp_r, v.exp_f, v.exp_lat);
    end

    // Reset two cycles into a shift: operation aborts, state returns to reset values.
    @(negedge clk);
    A = 4'd7; B = 4'd3; ALUControl = 3'd6; set_flags = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort flags", flags, 0);
    chk("abort result", result, 0);
    chk("abort in_ready", in_ready, 1);
    mflags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    model(3'd0, 4'd3, 4'd14, 1'b1, r, lat);
    do_op("post_reset_add", 3'd0, 4'd3, 4'd14, 1'b1, 0, 4'd1, 4'b0010, 1);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [3:0] a, b;
      logic       sf;
      int         st;
      op = 3'($urandom_range(0, 7));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      sf = 1'($urandom_range(0, 1));
      st = $urandom_range(0, 2);
      model(op, a, b, sf, r, lat);
      do_op($sformatf("rnd%0d", i), op, a, b, sf, st, r, mflags, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
